// File: rtl/simple_circuit.sv
// Registered gate network: D = (A & B) | ~C, E = ~C, delivered through a
// shift pipeline of PIPE_STAGES 2-bit registers (latency = PIPE_STAGES edges).
module simple_circuit #(
    parameter int PIPE_STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic D,
    output logic E
);

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_depth
            $error("simple_circuit: PIPE_STAGES must be in 1..4");
        end
    endgenerate

    logic w1;
    logic nc;
    logic d_comb;
    logic e_comb;

    assign w1     = A & B;
    assign nc     = ~C;
    assign d_comb = w1 | nc;
    assign e_comb = nc;

    // Each stage holds {D, E}; stage 0 captures the gate results.
    logic [1:0] pipe_q [PIPE_STAGES];
    logic [1:0] pipe_d [PIPE_STAGES];

    always_comb begin
        pipe_d[0] = {d_comb, e_comb};
        for (int i = 1; i < PIPE_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign D = pipe_q[PIPE_STAGES-1][1];
    assign E = pipe_q[PIPE_STAGES-1][0];

endmodule

// File: tb/tb_simple_circuit.sv
// Self-checking bench for simple_circuit at pipeline depths 1, 3 and 4,
// using a truth-table vector array and per-depth expected-value queues.
module tb_simple_circuit;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c;
    logic d1, e1, d3, e3, d4, e4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
    } vec_t;

    vec_t tbl [8];

    logic [1:0] q1 [$];
    logic [1:0] q3 [$];
    logic [1:0] q4 [$];

    always #5 clk = ~clk;

    simple_circuit #(.PIPE_STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d1), .E(e1)
    );
    simple_circuit #(.PIPE_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d3), .E(e3)
    );
    simple_circuit #(.PIPE_STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d4), .E(e4)
    );

    task automatic compare(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual D/E=%b required D/E=%b", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model(input logic ia, input logic ib, input logic ic);
        int idx;
        idx = {29'd0, ia, ib, ic};
        return {tbl[idx].d, tbl[idx].e};
    endfunction

    // Stages not yet refilled after reset read as 0/0, so seed depth-1 zeros.
    task automatic prefill();
        q1.delete();
        q3.delete();
        q4.delete();
        repeat (2) q3.push_back(2'b00);
        repeat (3) q4.push_back(2'b00);
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0] exp;
        if (rst_n) begin
            exp = q1.pop_front();
            compare({tag, "_p1"}, {d1, e1}, exp);
            exp = q3.pop_front();
            compare({tag, "_p3"}, {d3, e3}, exp);
            exp = q4.pop_front();
            compare({tag, "_p4"}, {d4, e4}, exp);
        end else begin
            compare({tag, "_p1_rst"}, {d1, e1}, 2'b00);
            compare({tag, "_p3_rst"}, {d3, e3}, 2'b00);
            compare({tag, "_p4_rst"}, {d4, e4}, 2'b00);
        end
    endtask

    task automatic applyStimulus(input logic ia, input logic ib, input logic ic, input string tag);
        @(negedge clk);
        a = ia;
        b = ib;
        c = ic;
        if (rst_n) begin
            q1.push_back(model(ia, ib, ic));
            q3.push_back(model(ia, ib, ic));
            q4.push_back(model(ia, ib, ic));
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        #1;
        compare("reset_p1", {d1, e1}, 2'b00);
        compare("reset_p3", {d3, e3}, 2'b00);
        compare("reset_p4", {d4, e4}, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prefill();

        // Exhaustive truth-table sweep; depth-1 result checked against the table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].a, tbl[i].b, tbl[i].c, $sformatf("sweep%0d", i));
            compare($sformatf("table%0d", i), {d1, e1}, {tbl[i].d, tbl[i].e});
        end

        // Latency at depth 3: hold 001, then 000 from edge k.
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, "hold001");
        applyStimulus(1'b0, 1'b0, 1'b0, "lat_k");
        compare("lat_k_p3", {d3, e3}, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, "lat_k1");
        compare("lat_k1_p3", {d3, e3}, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, "lat_k2");
        compare("lat_k2_p3", {d3, e3}, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b0, "lat_k3");
        compare("pre_async_p4", {d4, e4}, 2'b11);

        // Async reset asserted between edges.
        #3;
        rst_n = 1'b0;
        #1;
        compare("async_p1", {d1, e1}, 2'b00);
        compare("async_p3", {d3, e3}, 2'b00);
        compare("async_p4", {d4, e4}, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b0, "in_rst0");
        applyStimulus(1'b0, 1'b0, 1'b0, "in_rst1");
        rst_n = 1'b1;
        prefill();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, "post_async");

        // Reset mid-pipeline at depth 4: pre-reset vectors must never surface.
        applyStimulus(1'b0, 1'b0, 1'b0, "mid0");
        applyStimulus(1'b1, 1'b1, 1'b0, "mid1");
        applyStimulus(1'b1, 1'b1, 1'b1, "mid2");
        #2;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, "mid_rst0");
        applyStimulus(1'b1, 1'b1, 1'b0, "mid_rst1");
        rst_n = 1'b1;
        prefill();
        applyStimulus(1'b0, 1'b1, 1'b0, "rel0");
        compare("rel0_p4", {d4, e4}, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b1, "rel1");
        compare("rel1_p4", {d4, e4}, 2'b00);
        applyStimulus(1'b1, 1'b0, 1'b1, "rel2");
        compare("rel2_p4", {d4, e4}, 2'b00);
        applyStimulus(1'b1, 1'b0, 1'b1, "rel3");
        compare("rel3_p4", {d4, e4}, 2'b11);

        // C dominance with free-running A/B.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, "cdom0");
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, "cdom1");
        end

        // Back-to-back alternation.
        applyStimulus(1'b1, 1'b1, 1'b1, "alt0");
        compare("alt0_p1", {d1, e1}, 2'b10);
        applyStimulus(1'b0, 1'b0, 1'b1, "alt1");
        compare("alt1_p1", {d1, e1}, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b1, "alt2");
        compare("alt2_p1", {d1, e1}, 2'b10);
        applyStimulus(1'b0, 1'b0, 1'b1, "alt3");
        compare("alt3_p1", {d1, e1}, 2'b00);
        compare("alt3_p4", {d4, e4}, 2'b10);

        // Drain so the deep pipelines deliver every queued vector.
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
